// File: rtl/synth_bus_pkg.sv
// Shared definitions for the synth register bus sequencer.
//   - Voice register offsets within a voice bank.
//   - bus_state_t: externally visible sequencer state (IDLE/DECODE/SETUP/HIGH/LOW).
//   - seq_state_t: the parent controller's own phase.
//   - ev_kind_t: classification of an accepted note event, chosen at acceptance.
//   - write_entry_t: one register write {addr, data}.
//   - list_len / list_entry: the write list implied by an event kind.
// Optional feature macro used by the sequencer: VOICE_STEAL_EN.
package synth_bus_pkg;

    localparam logic [15:0] REG_GATE       = 16'd0;
    localparam logic [15:0] REG_INCR       = 16'd1;
    localparam logic [15:0] REG_WAVETYPE   = 16'd2;
    localparam logic [15:0] REG_PULSEWIDTH = 16'd3;
    localparam logic [15:0] REG_SUSTAIN    = 16'd4;
    localparam logic [15:0] REG_LINEAR     = 16'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_SETUP  = 3'd2,
        ST_HIGH   = 3'd3,
        ST_LOW    = 3'd4
    } bus_state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_DECODE = 2'd1,
        SEQ_WRITE  = 2'd2
    } seq_state_t;

    // EV_NONE: nothing to write (unmatched note-off or dropped note-on).
    // EV_ON:   Incr then Gate=1 (fresh allocation or retrigger).
    // EV_OFF:  Gate=0.
    // EV_STEAL: Gate=0, Incr, Gate=1 on a stolen voice.
    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_ON    = 2'd1,
        EV_OFF   = 2'd2,
        EV_STEAL = 2'd3
    } ev_kind_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } write_entry_t;

    function automatic logic [1:0] list_len(input ev_kind_t kind);
        case (kind)
            EV_ON:    return 2'd2;
            EV_OFF:   return 2'd1;
            EV_STEAL: return 2'd3;
            default:  return 2'd0;
        endcase
    endfunction

    // bank is the address of the voice's Gate register; sums wrap at 16 bits.
    function automatic write_entry_t list_entry(input ev_kind_t kind, input logic [1:0] idx,
                                                input logic [15:0] bank, input logic [7:0] incr);
        write_entry_t e;
        e = '0;
        case (kind)
            EV_ON: begin
                if (idx == 2'd0) begin
                    e.addr = bank + REG_INCR;
                    e.data = incr;
                end else if (idx == 2'd1) begin
                    e.addr = bank + REG_GATE;
                    e.data = 8'h01;
                end
            end
            EV_OFF: begin
                if (idx == 2'd0) begin
                    e.addr = bank + REG_GATE;
                    e.data = 8'h00;
                end
            end
            EV_STEAL: begin
                if (idx == 2'd0) begin
                    e.addr = bank + REG_GATE;
                    e.data = 8'h00;
                end else if (idx == 2'd1) begin
                    e.addr = bank + REG_INCR;
                    e.data = incr;
                end else if (idx == 2'd2) begin
                    e.addr = bank + REG_GATE;
                    e.data = 8'h01;
                end
            end
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/bus_write_cycle.sv
// Single register-write engine for the synth register bus.
// Sequence per write: SETUP (1 clock, strobe low) -> HIGH (BUS_HALF clocks,
// strobe high) -> LOW (BUS_HALF clocks, strobe low). Address/data are loaded
// at the SETUP edge and held until the write ends.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (bus outputs drop at once)
//   start, entry    request a write; sampled while idle or on the final LOW clock,
//                   so back-to-back writes need no idle gap
//   done            high during the final LOW clock of a write
//   state           engine state (ST_IDLE/ST_SETUP/ST_HIGH/ST_LOW) for observation
//   bus_address, bus_write_data, bus_read_write, bus_clock   registered bus outputs
module bus_write_cycle
    import synth_bus_pkg::*;
#(
    parameter int BUS_HALF = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  write_entry_t entry,
    output logic         done,
    output bus_state_t   state,
    output logic [15:0]  bus_address,
    output logic [7:0]   bus_write_data,
    output logic         bus_read_write,
    output logic         bus_clock
);

    localparam logic [15:0] HALF_LAST = 16'(BUS_HALF - 1);

    logic [15:0] half_cnt;
    logic        half_last;

    assign half_last = (half_cnt == HALF_LAST);
    assign done      = (state == ST_LOW) && half_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            half_cnt       <= '0;
            bus_address    <= '0;
            bus_write_data <= '0;
            bus_read_write <= 1'b0;
            bus_clock      <= 1'b0;
        end else if ((state == ST_IDLE || done) && start) begin
            state          <= ST_SETUP;
            half_cnt       <= '0;
            bus_address    <= entry.addr;
            bus_write_data <= entry.data;
            bus_read_write <= 1'b1;
            bus_clock      <= 1'b0;
        end else begin
            case (state)
                ST_SETUP: begin
                    state     <= ST_HIGH;
                    half_cnt  <= '0;
                    bus_clock <= 1'b1;
                end
                ST_HIGH: begin
                    if (half_last) begin
                        state     <= ST_LOW;
                        half_cnt  <= '0;
                        bus_clock <= 1'b0;
                    end else begin
                        half_cnt <= half_cnt + 16'd1;
                    end
                end
                ST_LOW: begin
                    if (half_last) begin
                        state          <= ST_IDLE;
                        half_cnt       <= '0;
                        bus_address    <= '0;
                        bus_write_data <= '0;
                        bus_read_write <= 1'b0;
                    end else begin
                        half_cnt <= half_cnt + 16'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    half_cnt  <= '0;
                    bus_clock <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/voice_bus_sequencer.sv
// Voice bus sequencer: turns note-on/note-off events into register writes on
// the synth register bus, allocating events across NUM_VOICES voice banks
// (voice v Gate at BASE_ADDR + v*VOICE_STRIDE, Incr one above).
// Handshake: an event is taken on a rising edge where NoteValid & NoteReady;
// NoteReady is high only while idle, so one event is in flight at a time.
// Optional feature macro VOICE_STEAL_EN: when defined, a note-on with every
// voice busy steals a voice via a rotating pointer; otherwise it is dropped
// and Overflow pulses for the DECODE clock.
// Ports:
//   Clock, Reset                 clock, asynchronous active-low reset
//   NoteValid/NoteReady          event handshake
//   NoteOn, NoteKey, NoteIncr    event payload
//   BusAddress, BusWriteData, BusReadWrite, BusClock   register bus (writes only)
//   VoiceActive                  gate state per voice (updated at the DECODE edge)
//   Overflow                     one-clock pulse when a note-on is dropped
//   DebugState                   current bus_state_t encoding
module voice_bus_sequencer
    import synth_bus_pkg::*;
#(
    parameter int          NUM_VOICES   = 4,
    parameter logic [15:0] BASE_ADDR    = 16'h0010,
    parameter logic [15:0] VOICE_STRIDE = 16'h0010,
    parameter int          BUS_HALF     = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  NoteValid,
    output logic                  NoteReady,
    input  logic                  NoteOn,
    input  logic [6:0]            NoteKey,
    input  logic [7:0]            NoteIncr,
    output logic [15:0]           BusAddress,
    output logic [7:0]            BusWriteData,
    output logic                  BusReadWrite,
    output logic                  BusClock,
    output logic [NUM_VOICES-1:0] VoiceActive,
    output logic                  Overflow,
    output logic [2:0]            DebugState
);

    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    seq_state_t   seq;
    logic [6:0]   key_tab [NUM_VOICES];
    ev_kind_t     ev_kind;
    logic [VW-1:0] ev_voice;
    logic [6:0]   ev_key;
    logic [7:0]   ev_incr;
    logic [1:0]   wr_idx;
`ifdef VOICE_STEAL_EN
    logic [VW-1:0] steal_ptr;
`endif

    logic          accept;
    logic          hit, free;
    logic [VW-1:0] hit_idx, free_idx;
    logic [15:0]   bank_addr;
    logic [1:0]    wr_len, next_idx, sel_idx;
    logic          eng_start, eng_done;
    write_entry_t  cur_entry;
    bus_state_t    eng_state;

    assign accept = NoteValid && NoteReady;

    // Key match and free-voice search against the live inputs, so the event
    // is fully classified at the acceptance edge. Scanning downwards makes
    // the lowest index win for both searches.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (VoiceActive[v] && (key_tab[v] == NoteKey)) begin
                hit     = 1'b1;
                hit_idx = VW'(v);
            end
            if (!VoiceActive[v]) begin
                free     = 1'b1;
                free_idx = VW'(v);
            end
        end
    end

    // Write list is a pure function of the latched event; the engine is fed
    // entry 0 during DECODE and entry wr_idx+1 on each write's final clock.
    assign bank_addr = BASE_ADDR + 16'(ev_voice) * VOICE_STRIDE;
    assign wr_len    = list_len(ev_kind);
    assign next_idx  = wr_idx + 2'd1;
    assign sel_idx   = (seq == SEQ_DECODE) ? 2'd0 : next_idx;
    assign cur_entry = list_entry(ev_kind, sel_idx, bank_addr, ev_incr);
    assign eng_start = ((seq == SEQ_DECODE) && (wr_len != 2'd0)) ||
                       ((seq == SEQ_WRITE) && eng_done && (next_idx < wr_len));

    always_comb begin
        case (seq)
            SEQ_DECODE: DebugState = ST_DECODE;
            SEQ_WRITE:  DebugState = eng_state;
            default:    DebugState = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            seq         <= SEQ_IDLE;
            NoteReady   <= 1'b0;
            VoiceActive <= '0;
            Overflow    <= 1'b0;
            ev_kind     <= EV_NONE;
            ev_voice    <= '0;
            ev_key      <= '0;
            ev_incr     <= '0;
            wr_idx      <= '0;
            for (int v = 0; v < NUM_VOICES; v++) key_tab[v] <= '0;
`ifdef VOICE_STEAL_EN
            steal_ptr   <= '0;
`endif
        end else begin
            Overflow <= 1'b0;
            case (seq)
                SEQ_IDLE: begin
                    if (accept) begin
                        NoteReady <= 1'b0;
                        seq       <= SEQ_DECODE;
                        ev_key    <= NoteKey;
                        ev_incr   <= NoteIncr;
                        if (NoteOn) begin
                            if (hit) begin
                                ev_kind  <= EV_ON;
                                ev_voice <= hit_idx;
                            end else if (free) begin
                                ev_kind  <= EV_ON;
                                ev_voice <= free_idx;
                            end else begin
`ifdef VOICE_STEAL_EN
                                ev_kind  <= EV_STEAL;
                                ev_voice <= steal_ptr;
`else
                                // Registered here so the pulse lines up with DECODE.
                                ev_kind  <= EV_NONE;
                                ev_voice <= '0;
                                Overflow <= 1'b1;
`endif
                            end
                        end else if (hit) begin
                            ev_kind  <= EV_OFF;
                            ev_voice <= hit_idx;
                        end else begin
                            ev_kind  <= EV_NONE;
                            ev_voice <= '0;
                        end
                    end else begin
                        NoteReady <= 1'b1;
                    end
                end
                SEQ_DECODE: begin
                    wr_idx <= '0;
                    case (ev_kind)
                        EV_ON, EV_STEAL: begin
                            VoiceActive[ev_voice] <= 1'b1;
                            key_tab[ev_voice]     <= ev_key;
                        end
                        EV_OFF: VoiceActive[ev_voice] <= 1'b0;
                        default: ;
                    endcase
`ifdef VOICE_STEAL_EN
                    if (ev_kind == EV_STEAL)
                        steal_ptr <= (steal_ptr == VW'(NUM_VOICES - 1)) ? '0 : steal_ptr + 1'b1;
`endif
                    if (wr_len == 2'd0) begin
                        seq       <= SEQ_IDLE;
                        NoteReady <= 1'b1;
                    end else begin
                        seq <= SEQ_WRITE;
                    end
                end
                SEQ_WRITE: begin
                    if (eng_done) begin
                        if (next_idx < wr_len) begin
                            wr_idx <= next_idx;
                        end else begin
                            seq       <= SEQ_IDLE;
                            NoteReady <= 1'b1;
                        end
                    end
                end
                default: begin
                    seq       <= SEQ_IDLE;
                    NoteReady <= 1'b0;
                end
            endcase
        end
    end

    bus_write_cycle #(.BUS_HALF(BUS_HALF)) u_bus (
        .clk            (Clock),
        .rst_n          (Reset),
        .start          (eng_start),
        .entry          (cur_entry),
        .done           (eng_done),
        .state          (eng_state),
        .bus_address    (BusAddress),
        .bus_write_data (BusWriteData),
        .bus_read_write (BusReadWrite),
        .bus_clock      (BusClock)
    );

endmodule
